alu_iter: RTL

//   Parametrised multi-cycle ALU for the RISC-V core execute stage, with valid/ready handshakes on input and output.

---
 rtl/alu_iter_pkg.sv | 21 ++
 rtl/alu_muldiv_iter.sv | 71 +++++++
 rtl/alu_iter.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared ALU opcode and FSM state encodings for alu_iter and its mul/div engine
package alu_iter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SUBU = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_MUL  = 4'd9,
    ALU_DIV  = 4'd10
  } alu_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned MUL (shift-add) / DIV (restoring) engine, BITS_PER_CYCLE bits per clock.
// Ports: clk, rst_n (async, active low), flush (abandon op), start (load a/b/op), op (alu opcode),
//        a, b (operands), done (high during the final iteration cycle), result (value after that iteration).
import alu_iter_pkg::*;
module alu_muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  logic          run, is_div;
  logic [CW-1:0] cnt;
  // x: multiplicand (mul) or dividend shifting into quotient (div); y: multiplier or divisor
  logic [XLEN-1:0] x, y, x_n, y_n;
  // acc: product accumulator (mul) or partial remainder with one guard bit (div)
  logic [XLEN:0]   acc, acc_n;
  always_comb begin
    x_n   = x;
    y_n   = y;
    acc_n = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (is_div) begin
        acc_n = {acc_n[XLEN-1:0], x_n[XLEN-1]};
        // a zero divisor always "fits", so the quotient naturally becomes all-ones
        x_n   = {x_n[XLEN-2:0], acc_n >= {1'b0, y}};
        acc_n = acc_n - (x_n[0] ? {1'b0, y} : '0);
      end else begin
        acc_n = acc_n + (y_n[0] ? {1'b0, x_n} : '0);
        x_n   = x_n << 1;
        y_n   = y_n >> 1;
      end
    end
  end
  assign done   = run & (cnt == CW'(N - 1));
  assign result = is_div ? x_n : acc_n[XLEN-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      acc    <= '0;
    end else if (flush) begin
      run <= 1'b0;
    end else if (start) begin
      run    <= 1'b1;
      is_div <= op == ALU_DIV;
      cnt    <= '0;
      x      <= a;
      y      <= b;
      acc    <= '0;
    end else if (run) begin
      x   <= x_n;
      y   <= y_n;
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      run <= ~done;
    end
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute-stage ALU with valid/ready handshakes; optional iterative MUL/DIV (macro ALU_MULDIV_EN).
// Ports: clk, rst_n (async, active low), flush (pipeline kill), in_valid/in_ready + aluop/alu_a/alu_b (request),
//        out_valid/out_ready + alu_result (registered response), busy (FSM not idle).
// Without ALU_MULDIV_EN, MUL/DIV are treated as unknown ops (result 0, single cycle).
import alu_iter_pkg::*;
module alu_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  if (XLEN % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must divide XLEN");
  end
  alu_state_e      state;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sc_result;
  logic            is_md;
  assign shamt     = alu_b[SW-1:0];
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign busy      = state != ST_IDLE;
  always_comb begin
    sc_result = '0;
    case (aluop)
      ALU_ADD:                 sc_result = alu_a + alu_b;
      ALU_SUB, ALU_SUBU:       sc_result = alu_a - alu_b;
      ALU_AND:                 sc_result = alu_a & alu_b;
      ALU_OR:                  sc_result = alu_a | alu_b;
      ALU_XOR:                 sc_result = alu_a ^ alu_b;
      ALU_SLL:                 sc_result = alu_a << shamt;
      ALU_SRL:                 sc_result = alu_a >> shamt;
      ALU_SRA:                 sc_result = $signed(alu_a) >>> shamt;
      default:                 sc_result = '0;
    endcase
  end
`ifdef ALU_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;
  assign is_md = (aluop == ALU_MUL) | (aluop == ALU_DIV);
  // flush wins over a same-cycle accept, so the engine must not start either
  alu_muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (in_valid & in_ready & is_md & ~flush),
    .op     (aluop),
    .a      (alu_a),
    .b      (alu_b),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign is_md = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state      <= is_md ? ST_CALC : ST_DONE;
          alu_result <= is_md ? alu_result : sc_result;
        end
`ifdef ALU_MULDIV_EN
        ST_CALC: if (md_done) begin
          state      <= ST_DONE;
          alu_result <= md_result;
        end
`endif
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
